// File: rtl/user_io_ctrl.sv
// user_io_ctrl: AHB-Lite slave controlling N_PADS GPIO pads with
// synchronised inputs, per-pad edge interrupts and N_IRQ interrupt lines.
// Optional feature macro: USER_IO_CTRL_TOGGLE_EN (TOGGLE registers at 0x30/0x34).
module user_io_ctrl #(
    parameter int N_PADS = 38,
    parameter int N_IRQ  = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic [N_PADS-1:0] io_in,
    output logic [N_PADS-1:0] io_out,
    output logic [N_PADS-1:0] io_oeb,
    output logic [N_IRQ-1:0]  user_irq
);

    // Register groups, indexed by word address bits [5:1]; bit 0 picks LO/HI.
    localparam logic [4:0] G_OUT    = 5'd0;
    localparam logic [4:0] G_OEB    = 5'd1;
    localparam logic [4:0] G_IN     = 5'd2;
    localparam logic [4:0] G_IRQEN  = 5'd3;
    localparam logic [4:0] G_STAT   = 5'd4;
    localparam logic [4:0] G_EDGE   = 5'd5;
    localparam logic [4:0] G_TOGGLE = 5'd6;

    logic              r_valid;
    logic              r_write;
    logic [2:0]        r_size;
    logic [5:0]        r_addr;
    logic [N_PADS-1:0] r_out;
    logic [N_PADS-1:0] r_oeb;
    logic [N_PADS-1:0] r_irqEn;
    logic [N_PADS-1:0] r_irqStat;
    logic [N_PADS-1:0] r_edge;
    logic [N_PADS-1:0] r_sync1;
    logic [N_PADS-1:0] r_sync2;
    logic [N_PADS-1:0] r_sync3;

    logic              w_accept;
    logic [4:0]        w_group;
    logic              w_hi;
    logic              w_wrEn;
    logic              w_rdEn;
    logic [63:0]       w_wrWide;
    logic [N_PADS-1:0] w_wrMask;
    logic [N_PADS-1:0] w_w1c;
    logic [N_PADS-1:0] w_edgeHit;
    logic              w_toggleSel;
    logic [63:0]       w_rdWide;
    logic              w_unused;

    // Replace the LO or HI 32-bit lane of a pad-wide register; bits at or
    // above N_PADS fall off the end, so HI writes beyond the pads vanish.
    function automatic logic [N_PADS-1:0] mergeWord(input logic [N_PADS-1:0] cur,
                                                     input logic hi,
                                                     input logic [31:0] data);
        logic [63:0] wide;
        wide = 64'(cur);
        if (hi) wide[63:32] = data;
        else    wide[31:0]  = data;
        return wide[N_PADS-1:0];
    endfunction

    assign HREADYOUT = 1'b1;
    assign w_accept  = HSEL & HREADY & HTRANS[1];
    assign w_group   = r_addr[5:1];
    assign w_hi      = r_addr[0];
    assign w_wrEn    = r_valid & r_write & (r_size == 3'b010);
    assign w_rdEn    = r_valid & ~r_write;
    assign w_wrWide  = w_hi ? {HWDATA, 32'h0} : {32'h0, HWDATA};
    assign w_wrMask  = w_wrWide[N_PADS-1:0];
    assign w_w1c     = (w_wrEn && w_group == G_STAT) ? w_wrMask : '0;
    assign w_unused  = &{1'b0, HADDR[31:8], HADDR[1:0], HTRANS[0]};

`ifdef USER_IO_CTRL_TOGGLE_EN
    assign w_toggleSel = (w_group == G_TOGGLE);
`else
    assign w_toggleSel = 1'b0;
`endif

    // A qualifying edge is a rise or fall of the synchronised input that
    // matches the pad's EDGE polarity, and only counts while enabled.
    assign w_edgeHit = ((r_sync2 & ~r_sync3 & r_edge) |
                        (~r_sync2 & r_sync3 & ~r_edge)) & r_irqEn;

    assign io_out = r_out;
    assign io_oeb = r_oeb;

    // Capture the address phase of each accepted transfer for its data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= 6'd0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_addr  <= HADDR[7:2];
            end
        end
    end

    // Commit word-sized writes to the RW registers at the end of the data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_out   <= '0;
            r_oeb   <= '1;
            r_irqEn <= '0;
            r_edge  <= '1;
        end else if (w_wrEn) begin
            if (w_group == G_OUT)        r_out   <= mergeWord(r_out, w_hi, HWDATA);
            else if (w_toggleSel)        r_out   <= r_out ^ w_wrMask;
            if (w_group == G_OEB)        r_oeb   <= mergeWord(r_oeb, w_hi, HWDATA);
            if (w_group == G_IRQEN)      r_irqEn <= mergeWord(r_irqEn, w_hi, HWDATA);
            if (w_group == G_EDGE)       r_edge  <= mergeWord(r_edge, w_hi, HWDATA);
        end
    end

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Sticky interrupt status; a new edge beats a simultaneous W1C clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_irqStat <= '0;
        else          r_irqStat <= (r_irqStat & ~w_w1c) | w_edgeHit;
    end

    // Select the addressed register as a 64-bit zero-extended value.
    always_comb begin
        w_rdWide = '0;
        case (w_group)
            G_OUT:   w_rdWide = 64'(r_out);
            G_OEB:   w_rdWide = 64'(r_oeb);
            G_IN:    w_rdWide = 64'(r_sync2);
            G_IRQEN: w_rdWide = 64'(r_irqEn);
            G_STAT:  w_rdWide = 64'(r_irqStat);
            G_EDGE:  w_rdWide = 64'(r_edge);
            default: w_rdWide = '0;
        endcase
    end

    assign HRDATA = w_rdEn ? (w_hi ? w_rdWide[63:32] : w_rdWide[31:0]) : 32'h0;

    // Interrupt line k collects every pad i with i mod N_IRQ == k.
    for (genvar k = 0; k < N_IRQ; k++) begin : g_irq
        logic [N_PADS-1:0] w_sel;
        for (genvar i = 0; i < N_PADS; i++) begin : g_pad
            assign w_sel[i] = ((i % N_IRQ) == k) ? (r_irqStat[i] & r_irqEn[i]) : 1'b0;
        end
        assign user_irq[k] = |w_sel;
    end

endmodule

// File: tb/tb_user_io_ctrl.sv
// tb_user_io_ctrl: directed test of user_io_ctrl with a read-data scoreboard.
// Define USER_IO_CTRL_TOGGLE_EN for both files to test the TOGGLE feature.
module tb_user_io_ctrl;

    localparam int N_PADS = 38;
    localparam int N_IRQ  = 3;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } expRead_t;

    logic              HCLK    = 1'b0;
    logic              HRESETn = 1'b0;
    logic              HSEL    = 1'b0;
    logic              HREADY  = 1'b1;
    logic              HWRITE  = 1'b0;
    logic [1:0]        HTRANS  = 2'b00;
    logic [2:0]        HSIZE   = 3'b010;
    logic [31:0]       HADDR   = 32'h0;
    logic [31:0]       HWDATA  = 32'h0;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic [N_PADS-1:0] io_in   = '0;
    logic [N_PADS-1:0] io_out;
    logic [N_PADS-1:0] io_oeb;
    logic [N_IRQ-1:0]  user_irq;

    int          checks    = 0;
    int          failures  = 0;
    expRead_t    expQ[$];
    logic        rdPhase;
    logic [7:0]  rdAddr;
    logic [31:0] nextWdata = 32'h0;

    user_io_ctrl #(.N_PADS(N_PADS), .N_IRQ(N_IRQ)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .user_irq(user_irq)
    );

    always #5 HCLK = ~HCLK;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // One bus cycle: drive this cycle's address phase and the previous write's data.
    task automatic applyStimulus(input logic act, input logic wr, input logic [7:0] addr,
                                 input logic [2:0] size, input logic [31:0] data);
        HWDATA = nextWdata;
        HSEL   = act;
        HTRANS = act ? 2'b10 : 2'b00;
        HWRITE = wr;
        HADDR  = {24'h0, addr};
        HSIZE  = size;
        if (act && !wr) expQ.push_back('{addr: addr, data: data});
        nextWdata = (act && wr) ? data : 32'h0;
        @(posedge HCLK);
        #1;
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, 3'b010, data);
    endtask

    task automatic readReg(input logic [7:0] addr, input logic [31:0] expData);
        applyStimulus(1'b1, 1'b0, addr, 3'b010, expData);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 3'b010, 32'h0);
    endtask

    // Track which cycles are read data phases, independently of the DUT.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdPhase <= 1'b0;
            rdAddr  <= 8'h00;
        end else begin
            rdPhase <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
            rdAddr  <= HADDR[7:0];
        end
    end

    // Monitor: pop the scoreboard on every read data phase, else expect HRDATA = 0.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (rdPhase) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rd@0x%0h actual=0x%0h expected=<none queued>", rdAddr, HRDATA);
                end else begin
                    expRead_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("rd@0x%0h", e.addr), 64'(HRDATA), 64'(e.data));
                end
            end else begin
                checkOutput("HRDATA_idle", 64'(HRDATA), 64'h0);
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        $display("[TB] start");
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("rst_io_out",   64'(io_out),   64'h0);
        checkOutput("rst_io_oeb",   64'(io_oeb),   64'h3F_FFFF_FFFF);
        checkOutput("rst_user_irq", 64'(user_irq), 64'h0);
        checkOutput("rst_HRDATA",   64'(HRDATA),   64'h0);
        checkOutput("rst_HREADYOUT", 64'(HREADYOUT), 64'h1);
        HRESETn = 1'b1;
        idle(1);

        // OEB reset values and pad directions
        readReg(8'h08, 32'hFFFF_FFFF);
        readReg(8'h0C, 32'h0000_003F);
        idle(1);
        checkOutput("io_oeb_after_rst", 64'(io_oeb), 64'h3F_FFFF_FFFF);

        // Write followed by back-to-back read of the same register
        writeReg(8'h00, 32'hA5A5_A5A5);
        checkOutput("io_out_before_commit", 64'(io_out), 64'h0);
        readReg(8'h00, 32'hA5A5_A5A5);
        checkOutput("io_out_lo", 64'(io_out[31:0]), 64'hA5A5_A5A5);

        // Sub-word write ignored, word write to HI keeps only real pads
        applyStimulus(1'b1, 1'b1, 8'h04, 3'b000, 32'hFFFF_FFFF);
        readReg(8'h04, 32'h0);
        writeReg(8'h04, 32'hFFFF_FFFF);
        readReg(8'h04, 32'h0000_003F);
        checkOutput("io_out_full", 64'(io_out), 64'h3F_A5A5_A5A5);

        // Unmapped offset and TOGGLE read-as-zero
        writeReg(8'h3C, 32'h1234_5678);
        readReg(8'h3C, 32'h0);
        readReg(8'h30, 32'h0);

        // Rising-edge interrupt on pad 4 -> user_irq[1]
        writeReg(8'h18, 32'h0000_0010);
        readReg(8'h28, 32'hFFFF_FFFF);
        readReg(8'h2C, 32'h0000_003F);
        idle(1);
        io_in[4] = 1'b1;
        idle(2);
        checkOutput("irq_not_yet", 64'(user_irq), 64'h0);
        idle(1);
        checkOutput("irq_pad4_set", 64'(user_irq), 64'h2);
        readReg(8'h20, 32'h0000_0010);
        readReg(8'h10, 32'h0000_0010);
        writeReg(8'h20, 32'h0000_0010);
        checkOutput("irq_before_w1c", 64'(user_irq), 64'h2);
        idle(1);
        checkOutput("irq_after_w1c", 64'(user_irq), 64'h0);

        // Falling edge does not match a rising-edge pad
        io_in[4] = 1'b0;
        idle(4);
        readReg(8'h20, 32'h0);
        io_in[4] = 1'b1;
        idle(4);
        checkOutput("irq_pad4_again", 64'(user_irq), 64'h2);

        // Disabling IRQ_EN masks the line but keeps status
        writeReg(8'h18, 32'h0);
        idle(1);
        checkOutput("irq_masked", 64'(user_irq), 64'h0);
        readReg(8'h20, 32'h0000_0010);
        writeReg(8'h18, 32'h0000_0010);
        io_in[4] = 1'b0;
        idle(4);

        // W1C and a fresh rising edge in the same cycle: set wins
        io_in[4] = 1'b1;
        idle(1);
        writeReg(8'h20, 32'h0000_0010);
        idle(1);
        readReg(8'h20, 32'h0000_0010);
        idle(1);
        checkOutput("irq_set_wins", 64'(user_irq), 64'h2);
        writeReg(8'h20, 32'h0000_0010);
        readReg(8'h20, 32'h0);

        // Falling-edge interrupt on HI pad 35 -> user_irq[2]
        writeReg(8'h1C, 32'h0000_0008);
        writeReg(8'h2C, 32'h0000_0037);
        readReg(8'h2C, 32'h0000_0037);
        io_in[35] = 1'b1;
        idle(4);
        checkOutput("irq_pad35_rise", 64'(user_irq), 64'h0);
        io_in[35] = 1'b0;
        idle(4);
        checkOutput("irq_pad35_fall", 64'(user_irq), 64'h4);
        readReg(8'h24, 32'h0000_0008);
        readReg(8'h14, 32'h0);

        // TOGGLE register
        writeReg(8'h00, 32'h0000_000F);
        writeReg(8'h30, 32'h0000_0003);
`ifdef USER_IO_CTRL_TOGGLE_EN
        readReg(8'h00, 32'h0000_000C);
`else
        readReg(8'h00, 32'h0000_000F);
`endif
        idle(1);

        // Reset asserted during a write data phase aborts the write
        writeReg(8'h00, 32'hDEAD_BEEF);
        HWDATA    = 32'hDEAD_BEEF;
        HSEL      = 1'b0;
        HTRANS    = 2'b00;
        nextWdata = 32'h0;
        HRESETn   = 1'b0;
        #2;
        checkOutput("midrst_io_out",   64'(io_out),   64'h0);
        checkOutput("midrst_io_oeb",   64'(io_oeb),   64'h3F_FFFF_FFFF);
        checkOutput("midrst_user_irq", 64'(user_irq), 64'h0);
        checkOutput("midrst_HRDATA",   64'(HRDATA),   64'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle(1);
        readReg(8'h00, 32'h0);
        readReg(8'h24, 32'h0);
        idle(2);

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
